// File: rtl/ntt_r4_sched_if.sv
// ntt_r4_sched_if: handshake, ROM and BRAM strobe/address bundle of the radix-4 NTT sequencer.
interface ntt_r4_sched_if #(parameter int AW = 8);
  logic          i_start;
  logic          i_inverse;
  logic          o_busy;
  logic          o_done;
  logic          o_mode_inv;
  logic [1:0]    o_stage;
  logic          o_rom_re;
  logic [AW-1:0] o_rom_idx;
  logic [AW-1:0] i_addr0, i_addr1, i_addr2, i_addr3;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr0, o_rd_addr1, o_rd_addr2, o_rd_addr3;
  logic          o_bf_valid;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr0, o_wr_addr1, o_wr_addr2, o_wr_addr3;
  modport master (
    output i_start, i_inverse, i_addr0, i_addr1, i_addr2, i_addr3,
    input  o_busy, o_done, o_mode_inv, o_stage, o_rom_re, o_rom_idx,
           o_rd_en, o_rd_addr0, o_rd_addr1, o_rd_addr2, o_rd_addr3, o_bf_valid,
           o_wr_en, o_wr_addr0, o_wr_addr1, o_wr_addr2, o_wr_addr3
  );
  modport slave (
    input  i_start, i_inverse, i_addr0, i_addr1, i_addr2, i_addr3,
    output o_busy, o_done, o_mode_inv, o_stage, o_rom_re, o_rom_idx,
           o_rd_en, o_rd_addr0, o_rd_addr1, o_rd_addr2, o_rd_addr3, o_bf_valid,
           o_wr_en, o_wr_addr0, o_wr_addr1, o_wr_addr2, o_wr_addr3
  );
endinterface

// File: rtl/ntt_r4_sched.sv
// ntt_r4_sched: stage/butterfly sequencer for a 256-point radix-4 NTT with pipeline-aligned BRAM strobes.
module ntt_r4_sched #(
  parameter int N_BF     = 64,
  parameter int N_STG    = 4,
  parameter int ROM_LAT  = 1,
  parameter int BRAM_LAT = 1,
  parameter int BF_LAT   = 6,
  parameter int AW       = 8
) (
  input logic           clk,
  input logic           rst,
  ntt_r4_sched_if.slave io_bus
);
  localparam int D  = ROM_LAT + BRAM_LAT + BF_LAT;
  localparam int NP = BRAM_LAT + BF_LAT - 1;
  localparam int BW = $clog2(N_BF);
  localparam int CW = $clog2(D + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      r_stage;
  logic [BW-1:0]   r_bf;
  logic [CW-1:0]   r_cnt;
  logic            r_inv;
  logic [D-1:0]    r_v;
  logic [4*AW-1:0] r_ap [NP];
  logic [4*AW-1:0] r_wa;
  logic            w_rom_re;
  logic            w_rd_en;
  logic [4*AW-1:0] w_addr;

  assign w_rom_re = r_state == S_ISSUE;
  assign w_rd_en  = r_v[ROM_LAT-1];
  assign w_addr   = {io_bus.i_addr3, io_bus.i_addr2, io_bus.i_addr1, io_bus.i_addr0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.i_start) begin
          r_inv   <= io_bus.i_inverse;
          r_stage <= '0;
          r_bf    <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: if (r_bf == BW'(N_BF - 1)) begin
          r_state <= S_DRAIN;
          r_cnt   <= CW'(D);
        end else begin
          r_bf <= r_bf + 1'b1;
        end
        S_DRAIN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            if (r_stage == 2'(N_STG - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_stage <= r_stage + 1'b1;
              r_bf    <= '0;
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // addresses are shifted every cycle; only the slot tagged by the valid line is committed to wr_addr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_wa <= '0;
      for (int j = 0; j < NP; j++) r_ap[j] <= '0;
    end else begin
      r_v     <= {r_v[D-2:0], w_rom_re};
      r_ap[0] <= w_addr;
      for (int j = 1; j < NP; j++) r_ap[j] <= r_ap[j-1];
      if (r_v[D-2]) r_wa <= r_ap[NP-1];
    end
  end

  assign io_bus.o_busy     = r_state != S_IDLE;
  assign io_bus.o_done     = r_state == S_DONE;
  assign io_bus.o_mode_inv = r_inv;
  assign io_bus.o_stage    = r_stage;
  assign io_bus.o_rom_re   = w_rom_re;
  assign io_bus.o_rom_idx  = AW'({r_stage, r_bf});
  assign io_bus.o_rd_en    = w_rd_en;
  assign io_bus.o_rd_addr0 = w_rd_en ? io_bus.i_addr0 : '0;
  assign io_bus.o_rd_addr1 = w_rd_en ? io_bus.i_addr1 : '0;
  assign io_bus.o_rd_addr2 = w_rd_en ? io_bus.i_addr2 : '0;
  assign io_bus.o_rd_addr3 = w_rd_en ? io_bus.i_addr3 : '0;
  assign io_bus.o_bf_valid = r_v[ROM_LAT+BRAM_LAT-1];
  assign io_bus.o_wr_en    = r_v[D-1];
  assign io_bus.o_wr_addr0 = r_wa[AW-1:0];
  assign io_bus.o_wr_addr1 = r_wa[2*AW-1:AW];
  assign io_bus.o_wr_addr2 = r_wa[3*AW-1:2*AW];
  assign io_bus.o_wr_addr3 = r_wa[4*AW-1:3*AW];
endmodule
